// File: rtl/execute_stage.sv
// Execute stage: ALU, NZCV condition check and condition-gated Execute->Memory register.
// Latency 1 cycle; stall_m holds the E/M register and flags, flush_m loads a bubble.
// Optional failed-condition counter enabled by defining EXEC_SQUASH_CNT_EN.
module execute_stage #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] rd1_e,
    input  logic [WIDTH-1:0] rd2_e,
    input  logic [WIDTH-1:0] imm_ext_e,
    input  logic [3:0]       wa3_e,
    input  logic             valid_e,
    input  logic             pc_src_e,
    input  logic             reg_write_e,
    input  logic             mem_to_reg_e,
    input  logic             mem_write_e,
    input  logic             alu_src_e,
    input  logic [1:0]       flag_write_e,
    input  logic [2:0]       alu_control_e,
    input  logic [3:0]       cond_e,
    input  logic             stall_m,
    input  logic             flush_m,
    output logic [WIDTH-1:0] alu_result_m,
    output logic [WIDTH-1:0] write_data_m,
    output logic [3:0]       wa3_m,
    output logic             pc_src_m,
    output logic             reg_write_m,
    output logic             mem_to_reg_m,
    output logic             mem_write_m,
    output logic [3:0]       flags,
    output logic [15:0]      squash_cnt
);
    logic [WIDTH-1:0] w_src_b;
    logic [WIDTH-1:0] w_result;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic             w_c;
    logic             w_v;
    logic             w_n;
    logic             w_z;
    logic             w_cond_true;
    logic             w_cond_ex;
    logic             w_load;
    logic [3:0]       r_flags;
    logic             w_fn, w_fz, w_fc, w_fv;

    assign w_src_b = alu_src_e ? imm_ext_e : rd2_e;
    assign w_sum   = {1'b0, rd1_e} + {1'b0, w_src_b};
    assign w_diff  = {1'b0, rd1_e} - {1'b0, w_src_b};

    always_comb begin
        w_result = '0;
        w_c      = 1'b0;
        w_v      = 1'b0;
        case (alu_control_e)
            3'b000: begin
                w_result = w_sum[WIDTH-1:0];
                w_c      = w_sum[WIDTH];
                w_v      = (rd1_e[WIDTH-1] == w_src_b[WIDTH-1]) &&
                           (w_sum[WIDTH-1] != rd1_e[WIDTH-1]);
            end
            3'b001: begin
                // Carry is NOT borrow: set when A >= B unsigned.
                w_result = w_diff[WIDTH-1:0];
                w_c      = ~w_diff[WIDTH];
                w_v      = (rd1_e[WIDTH-1] != w_src_b[WIDTH-1]) &&
                           (w_diff[WIDTH-1] != rd1_e[WIDTH-1]);
            end
            3'b010:  w_result = rd1_e & w_src_b;
            3'b011:  w_result = rd1_e | w_src_b;
            3'b100:  w_result = rd1_e ^ w_src_b;
            3'b101:  w_result = w_src_b;
            3'b110:  w_result = rd1_e & ~w_src_b;
            default: w_result = '0;
        endcase
    end

    assign w_n = w_result[WIDTH-1];
    assign w_z = (w_result == '0);

    // Condition sees the committed flags, i.e. those of the instruction one ahead.
    assign {w_fn, w_fz, w_fc, w_fv} = r_flags;

    always_comb begin
        w_cond_true = 1'b0;
        case (cond_e)
            4'b0000: w_cond_true = w_fz;
            4'b0001: w_cond_true = ~w_fz;
            4'b0010: w_cond_true = w_fc;
            4'b0011: w_cond_true = ~w_fc;
            4'b0100: w_cond_true = w_fn;
            4'b0101: w_cond_true = ~w_fn;
            4'b0110: w_cond_true = w_fv;
            4'b0111: w_cond_true = ~w_fv;
            4'b1000: w_cond_true = w_fc & ~w_fz;
            4'b1001: w_cond_true = ~w_fc | w_fz;
            4'b1010: w_cond_true = (w_fn == w_fv);
            4'b1011: w_cond_true = (w_fn != w_fv);
            4'b1100: w_cond_true = ~w_fz & (w_fn == w_fv);
            4'b1101: w_cond_true = w_fz | (w_fn != w_fv);
            default: w_cond_true = 1'b1;
        endcase
    end

    assign w_cond_ex = valid_e & w_cond_true;
    assign w_load    = ~flush_m & ~stall_m;

    always_ff @(posedge clk) begin
        if (reset || flush_m) begin
            alu_result_m <= '0;
            write_data_m <= '0;
            wa3_m        <= '0;
            pc_src_m     <= 1'b0;
            reg_write_m  <= 1'b0;
            mem_to_reg_m <= 1'b0;
            mem_write_m  <= 1'b0;
        end else if (!stall_m) begin
            alu_result_m <= w_result;
            write_data_m <= rd2_e;
            wa3_m        <= wa3_e;
            pc_src_m     <= pc_src_e & w_cond_ex;
            reg_write_m  <= reg_write_e & w_cond_ex;
            mem_to_reg_m <= mem_to_reg_e & valid_e;
            mem_write_m  <= mem_write_e & w_cond_ex;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_flags <= 4'b0000;
        end else if (w_load && w_cond_ex) begin
            if (flag_write_e[1]) r_flags[3:2] <= {w_n, w_z};
            if (flag_write_e[0]) r_flags[1:0] <= {w_c, w_v};
        end
    end

    assign flags = r_flags;

`ifdef EXEC_SQUASH_CNT_EN
    logic [15:0] r_squash_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_squash_cnt <= '0;
        end else if (w_load && valid_e && !w_cond_true && (r_squash_cnt != 16'hFFFF)) begin
            r_squash_cnt <= r_squash_cnt + 16'd1;
        end
    end

    assign squash_cnt = r_squash_cnt;
`else
    assign squash_cnt = '0;
`endif

endmodule

// File: tb/tb_execute_stage.sv
// Directed testbench for execute_stage with hand-computed expected values.
module tb_execute_stage;
    localparam int WIDTH = 32;
`ifdef EXEC_SQUASH_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic [WIDTH-1:0] rd1_e, rd2_e, imm_ext_e;
    logic [3:0]       wa3_e;
    logic             valid_e, pc_src_e, reg_write_e, mem_to_reg_e, mem_write_e, alu_src_e;
    logic [1:0]       flag_write_e;
    logic [2:0]       alu_control_e;
    logic [3:0]       cond_e;
    logic             stall_m, flush_m;
    logic [WIDTH-1:0] alu_result_m, write_data_m;
    logic [3:0]       wa3_m;
    logic             pc_src_m, reg_write_m, mem_to_reg_m, mem_write_m;
    logic [3:0]       flags;
    logic [15:0]      squash_cnt;

    int n_cmp = 0;
    int n_mis = 0;
    int n_sq  = 0;

    execute_stage #(.WIDTH(WIDTH)) dut (
        .clk(clk), .reset(reset),
        .rd1_e(rd1_e), .rd2_e(rd2_e), .imm_ext_e(imm_ext_e), .wa3_e(wa3_e),
        .valid_e(valid_e), .pc_src_e(pc_src_e), .reg_write_e(reg_write_e),
        .mem_to_reg_e(mem_to_reg_e), .mem_write_e(mem_write_e), .alu_src_e(alu_src_e),
        .flag_write_e(flag_write_e), .alu_control_e(alu_control_e), .cond_e(cond_e),
        .stall_m(stall_m), .flush_m(flush_m),
        .alu_result_m(alu_result_m), .write_data_m(write_data_m), .wa3_m(wa3_m),
        .pc_src_m(pc_src_m), .reg_write_m(reg_write_m), .mem_to_reg_m(mem_to_reg_m),
        .mem_write_m(mem_write_m), .flags(flags), .squash_cnt(squash_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // {pc_src, reg_write, mem_to_reg, mem_write} packed as ctl.
    task automatic instr(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] imm, input logic src_imm, input logic [3:0] cond,
                         input logic [1:0] fw, input logic [3:0] ctl, input logic [3:0] wa);
        alu_control_e = op;
        rd1_e         = a;
        rd2_e         = b;
        imm_ext_e     = imm;
        alu_src_e     = src_imm;
        cond_e        = cond;
        flag_write_e  = fw;
        {pc_src_e, reg_write_e, mem_to_reg_e, mem_write_e} = ctl;
        wa3_e         = wa;
        valid_e       = 1'b1;
    endtask

    task automatic chk_ctl(input string tag, input logic [3:0] exp);
        chk(tag, {28'd0, pc_src_m, reg_write_m, mem_to_reg_m, mem_write_m}, {28'd0, exp});
    endtask

    task automatic chk_cnt(input string tag);
        chk(tag, {16'd0, squash_cnt}, CNT_ON ? n_sq : 0);
    endtask

    initial begin
        reset = 1'b1; stall_m = 1'b0; flush_m = 1'b0;
        instr(3'b000, 32'd0, 32'd0, 32'd0, 1'b0, 4'b1110, 2'b00, 4'b0000, 4'd0);
        valid_e = 1'b0;
        tick(); tick();
        chk("rst_res", alu_result_m, 32'd0);
        chk("rst_wd", write_data_m, 32'd0);
        chk_ctl("rst_ctl", 4'b0000);
        chk("rst_flags", {28'd0, flags}, 32'd0);
        chk_cnt("rst_cnt");
        reset = 1'b0;

        // ADDS overflow: 0x7FFFFFFF + 1
        instr(3'b000, 32'h7FFFFFFF, 32'd1, 32'd0, 1'b0, 4'b1110, 2'b11, 4'b1100, 4'd3);
        tick();
        chk("adds_res", alu_result_m, 32'h80000000);
        chk("adds_flags", {28'd0, flags}, 32'b1001);
        chk_ctl("adds_ctl", 4'b1100);
        chk("adds_wa", {28'd0, wa3_m}, 32'd3);
        chk("adds_wd", write_data_m, 32'd1);

        // SUBS 5-5 -> Z=1 C=1
        instr(3'b001, 32'd5, 32'd5, 32'd0, 1'b0, 4'b1110, 2'b11, 4'b0000, 4'd1);
        tick();
        chk("subs_res", alu_result_m, 32'd0);
        chk("subs_flags", {28'd0, flags}, 32'b0110);

        // ADDEQ with immediate operand
        instr(3'b000, 32'd2, 32'd9, 32'd3, 1'b1, 4'b0000, 2'b00, 4'b0100, 4'd4);
        tick();
        chk("addeq_res", alu_result_m, 32'd5);
        chk_ctl("addeq_ctl", 4'b0100);

        // ADDNE fails: no write, counter +1
        instr(3'b000, 32'd2, 32'd9, 32'd3, 1'b1, 4'b0001, 2'b11, 4'b0100, 4'd4);
        tick(); n_sq++;
        chk_ctl("addne_ctl", 4'b0000);
        chk("addne_flags", {28'd0, flags}, 32'b0110);
        chk_cnt("addne_cnt");

        // STRMI with N=0: store suppressed, data still passes, mem_to_reg only valid-gated
        instr(3'b000, 32'h100, 32'hDEADBEEF, 32'h10, 1'b1, 4'b0100, 2'b00, 4'b1011, 4'd5);
        tick(); n_sq++;
        chk_ctl("mi_ctl", 4'b0010);
        chk("mi_wd", write_data_m, 32'hDEADBEEF);
        chk("mi_res", alu_result_m, 32'h110);
        chk_cnt("mi_cnt");

        // Logical ops
        instr(3'b010, 32'h0000F0F0, 32'h0000FF00, 32'd0, 1'b0, 4'b1111, 2'b00, 4'b0100, 4'd6);
        tick(); chk("and_res", alu_result_m, 32'h0000F000);
        instr(3'b011, 32'h000000F0, 32'h00000F00, 32'd0, 1'b0, 4'b1110, 2'b00, 4'b0100, 4'd6);
        tick(); chk("orr_res", alu_result_m, 32'h00000FF0);
        instr(3'b100, 32'h000000FF, 32'h0000000F, 32'd0, 1'b0, 4'b1110, 2'b00, 4'b0100, 4'd6);
        tick(); chk("eor_res", alu_result_m, 32'h000000F0);
        instr(3'b101, 32'hAAAAAAAA, 32'h0, 32'h1234, 1'b1, 4'b1110, 2'b00, 4'b0100, 4'd6);
        tick(); chk("mov_res", alu_result_m, 32'h00001234);
        instr(3'b110, 32'h000000FF, 32'h0000000F, 32'd0, 1'b0, 4'b1110, 2'b00, 4'b0100, 4'd6);
        tick(); chk("bic_res", alu_result_m, 32'h000000F0);
        instr(3'b111, 32'h12345678, 32'h1, 32'd0, 1'b0, 4'b1110, 2'b00, 4'b0100, 4'd6);
        tick(); chk("zero_res", alu_result_m, 32'h0);

        // ANDS clears C,V: N=1 Z=0 C=0 V=0
        instr(3'b010, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1'b0, 4'b1110, 2'b11, 4'b0000, 4'd0);
        tick();
        chk("ands_flags", {28'd0, flags}, 32'b1000);

        // LT true, GE false
        instr(3'b000, 32'd1, 32'd1, 32'd0, 1'b0, 4'b1011, 2'b00, 4'b0100, 4'd2);
        tick(); chk_ctl("lt_ctl", 4'b0100);
        instr(3'b000, 32'd1, 32'd1, 32'd0, 1'b0, 4'b1010, 2'b00, 4'b0100, 4'd2);
        tick(); n_sq++;
        chk_ctl("ge_ctl", 4'b0000);
        chk_cnt("ge_cnt");

        // Bubble: nothing gated through, counter untouched
        instr(3'b000, 32'd1, 32'd1, 32'd0, 1'b0, 4'b0000, 2'b11, 4'b1111, 4'd2);
        valid_e = 1'b0;
        tick();
        chk_ctl("bub_ctl", 4'b0000);
        chk("bub_flags", {28'd0, flags}, 32'b1000);
        chk_cnt("bub_cnt");

        // ADDS 1+1 -> flags 0000
        instr(3'b000, 32'd1, 32'd1, 32'd0, 1'b0, 4'b1110, 2'b11, 4'b0100, 4'd2);
        tick();
        chk("pre_flags", {28'd0, flags}, 32'b0000);
        chk("pre_res", alu_result_m, 32'd2);

        // SUBS 3-5 held by stall for 3 cycles
        instr(3'b001, 32'd3, 32'd5, 32'd0, 1'b0, 4'b1110, 2'b11, 4'b0100, 4'd7);
        stall_m = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stl_res", alu_result_m, 32'd2);
            chk("stl_wa", {28'd0, wa3_m}, 32'd2);
            chk("stl_flags", {28'd0, flags}, 32'b0000);
        end
        stall_m = 1'b0;
        tick();
        chk("rel_res", alu_result_m, 32'hFFFFFFFE);
        chk("rel_wa", {28'd0, wa3_m}, 32'd7);
        chk("rel_flags", {28'd0, flags}, 32'b1000);

        // flush+stall with valid ADDS: bubble, flags unchanged
        instr(3'b000, 32'd1, 32'd1, 32'd0, 1'b0, 4'b1110, 2'b11, 4'b1111, 4'd9);
        stall_m = 1'b1; flush_m = 1'b1;
        tick();
        chk_ctl("fl_ctl", 4'b0000);
        chk("fl_res", alu_result_m, 32'd0);
        chk("fl_wd", write_data_m, 32'd0);
        chk("fl_flags", {28'd0, flags}, 32'b1000);

        // Flush of a failing instruction leaves counter alone
        stall_m = 1'b0;
        cond_e = 4'b0000;
        tick();
        chk_cnt("fl_cnt");
        flush_m = 1'b0;

        // Reset during active load
        instr(3'b000, 32'h7FFFFFFF, 32'd1, 32'd0, 1'b0, 4'b1110, 2'b11, 4'b1111, 4'd8);
        reset = 1'b1;
        tick();
        n_sq = 0;
        chk("ral_res", alu_result_m, 32'd0);
        chk_ctl("ral_ctl", 4'b0000);
        chk("ral_flags", {28'd0, flags}, 32'd0);
        chk_cnt("ral_cnt");
        reset = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
